// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared constants and slot state type for the adder arbiter
package adder_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    localparam logic FIXED_PRIO  = 1'b0;
    localparam logic ROUND_ROBIN = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// rtl/adder_arbiter_rr_picker.sv - combinational request picker, fixed or rotating priority
module rr_picker
    import adder_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    input  logic               mode,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Pick a winner: rotating search from start, or highest set index in fixed mode.
    // Loops run so the last assignment is the highest-priority candidate.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand  = '0;
        grant = '0;
        idx   = '0;
        any   = |req;
        if (mode == ROUND_ROBIN) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = start + ID_W'(k);
                if (req[cand]) begin
                    idx = cand;
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    idx = ID_W'(i);
                end
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - four requesters sharing one adder behind a one-entry result slot
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter bit RR_MODE = 1'b1
)
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_in,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic [WIDTH:0]         result_out,
    output logic [ID_W-1:0]        result_id_out,
    output logic                   result_valid_out,
    input  logic                   result_ready_in,
    output logic                   busy_out,
    output logic [15:0]            ops_count_out
);

    slot_state_t state;
    slot_state_t state_next;

    logic [ID_W-1:0]    last_id;
    logic [ID_W-1:0]    start_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               grant_fire;
    logic               accept;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

    assign start_idx = last_id + ID_W'(1);

    rr_picker u_picker (
        .req   (req_in),
        .start (start_idx),
        .mode  (RR_MODE),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Operand mux follows the picker only, so grant_out never depends on operand data.
    assign op_a = a_in[int'(pick_idx) * WIDTH +: WIDTH];
    assign op_b = b_in[int'(pick_idx) * WIDTH +: WIDTH];

    // Slot next-state and handshake outputs; reset masks the grant so nothing is captured.
    always_comb begin
        state_next       = state;
        grant_fire       = 1'b0;
        accept           = 1'b0;
        grant_out        = '0;
        result_valid_out = 1'b0;
        busy_out         = 1'b0;
        if (!rst_in) begin
            accept     = (state == FULL) && result_ready_in;
            grant_fire = pick_any && ((state == EMPTY) || result_ready_in);
        end
        if (grant_fire) begin
            grant_out = pick_grant;
        end
        case (state)
            EMPTY: begin
                if (grant_fire) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                result_valid_out = 1'b1;
                busy_out         = !result_ready_in;
                if (accept && !grant_fire) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Capture the zero-extended sum and winner ID on every grant, including back-to-back reloads.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            result_out    <= '0;
            result_id_out <= '0;
        end else if (grant_fire) begin
            result_out    <= {1'b0, op_a} + {1'b0, op_b};
            result_id_out <= pick_idx;
        end
    end

    // Rotation pointer starts at 3 so the first search begins at index 0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_id <= ID_W'(NUM_REQ - 1);
        end else if (grant_fire) begin
            last_id <= pick_idx;
        end
    end

    // Count results taken by the consumer; wraps naturally at 16 bits.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ops_count_out <= '0;
        end else if (accept) begin
            ops_count_out <= ops_count_out + 16'd1;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter in both priority modes
module tb_adder_arbiter;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;

    logic [3:0]     req_rr, req_fp;
    logic           rdy_rr, rdy_fp;
    logic [4*W-1:0] a_bus, b_bus;

    logic [3:0]  g_rr, g_fp;
    logic [W:0]  res_rr, res_fp;
    logic [1:0]  id_rr, id_fp;
    logic        v_rr, v_fp, busy_rr, busy_fp;
    logic [15:0] cnt_rr, cnt_fp;

    int nvec = 0;
    int nerr = 0;

    // index 0 models the round-robin instance, index 1 the fixed-priority one
    bit          m_full [2] = '{1'b0, 1'b0};
    logic [W:0]  m_sum  [2] = '{'0, '0};
    logic [1:0]  m_id   [2] = '{2'd0, 2'd0};
    logic [1:0]  m_last [2] = '{2'd3, 2'd3};
    logic [15:0] m_cnt  [2] = '{16'd0, 16'd0};

    logic [3:0] tg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W:0] tr [4] = '{17'h00001, 17'h00101, 17'h00201, 17'h00301};

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W), .RR_MODE(1'b1)) dut (
        .clk_in(clk), .rst_in(rst), .req_in(req_rr), .a_in(a_bus), .b_in(b_bus),
        .grant_out(g_rr), .result_out(res_rr), .result_id_out(id_rr),
        .result_valid_out(v_rr), .result_ready_in(rdy_rr), .busy_out(busy_rr),
        .ops_count_out(cnt_rr)
    );

    adder_arbiter #(.WIDTH(W), .RR_MODE(1'b0)) dut_fp (
        .clk_in(clk), .rst_in(rst), .req_in(req_fp), .a_in(a_bus), .b_in(b_bus),
        .grant_out(g_fp), .result_out(res_fp), .result_id_out(id_fp),
        .result_valid_out(v_fp), .result_ready_in(rdy_fp), .busy_out(busy_fp),
        .ops_count_out(cnt_fp)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int pick(input int m, input logic [3:0] req);
        if (m == 1) begin
            for (int i = 3; i >= 0; i--) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (req[(int'(m_last[m]) + k) % 4]) return (int'(m_last[m]) + k) % 4;
        end
        return 0;
    endfunction

    function automatic logic [3:0] exp_grant(input int m, input logic [3:0] req, input logic rdy);
        if (rst || req == 4'b0000 || (m_full[m] && !rdy)) return 4'b0000;
        return 4'b0001 << pick(m, req);
    endfunction

    task automatic upd(input int m, input logic [3:0] req, input logic rdy);
        logic [3:0] g;
        int i;
        g = exp_grant(m, req, rdy);
        if (m_full[m] && rdy) m_cnt[m] = m_cnt[m] + 16'd1;
        if (g != 4'b0000) begin
            i = pick(m, req);
            m_full[m] = 1'b1;
            m_sum[m]  = {1'b0, a_bus[i*W +: W]} + {1'b0, b_bus[i*W +: W]};
            m_id[m]   = i[1:0];
            m_last[m] = i[1:0];
        end else if (m_full[m] && rdy) begin
            m_full[m] = 1'b0;
        end
    endtask

    // model advances on the same edges as the DUTs
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                m_full[m] = 1'b0;
                m_sum[m]  = '0;
                m_id[m]   = 2'd0;
                m_last[m] = 2'd3;
                m_cnt[m]  = 16'd0;
            end
        end else begin
            upd(0, req_rr, rdy_rr);
            upd(1, req_fp, rdy_fp);
        end
    end

    task automatic cmp_inst(input int m, input logic [3:0] g, input logic [3:0] req, input logic rdy,
                            input logic v, input logic busy, input logic [W:0] res,
                            input logic [1:0] id, input logic [15:0] cnt);
        chk($sformatf("m%0d_grant", m), 32'(g), 32'(exp_grant(m, req, rdy)));
        chk($sformatf("m%0d_valid", m), 32'(v), 32'(m_full[m]));
        chk($sformatf("m%0d_busy", m), 32'(busy), 32'(m_full[m] && !rdy && !rst));
        chk($sformatf("m%0d_count", m), 32'(cnt), 32'(m_cnt[m]));
        if (m_full[m]) begin
            chk($sformatf("m%0d_result", m), 32'(res), 32'(m_sum[m]));
            chk($sformatf("m%0d_id", m), 32'(id), 32'(m_id[m]));
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, g_rr, req_rr, rdy_rr, v_rr, busy_rr, res_rr, id_rr, cnt_rr);
            cmp_inst(1, g_fp, req_fp, rdy_fp, v_fp, busy_fp, res_fp, id_fp, cnt_fp);
        end
    end

    initial begin
        req_rr = 4'b0000; req_fp = 4'b0000;
        rdy_rr = 1'b1;    rdy_fp = 1'b1;
        a_bus  = '0;      b_bus  = '0;
        repeat (2) @(posedge clk);
        #1;
        req_rr = 4'b1111;
        #1;
        chk("rst_grant", 32'(g_rr), 32'h0);
        chk("rst_valid", 32'(v_rr), 32'h0);
        chk("rst_result", 32'(res_rr), 32'h0);
        chk("rst_id", 32'(id_rr), 32'h0);
        chk("rst_busy", 32'(busy_rr), 32'h0);
        chk("rst_count", 32'(cnt_rr), 32'h0);
        req_rr = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // basic round robin
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            a_bus[i*W +: W] = 16'(16'h0100 * i);
            b_bus[i*W +: W] = 16'h0001;
        end
        req_rr = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant_seq", 32'(g_rr), 32'(tg[k]));
            if (k > 0) begin
                chk("rr_id_seq", 32'(id_rr), 32'(k - 1));
                chk("rr_result_seq", 32'(res_rr), 32'(tr[k-1]));
            end
        end

        // carry-out
        @(posedge clk); #1;
        a_bus[1*W +: W] = 16'hFFFF;
        b_bus[1*W +: W] = 16'hFFFF;
        req_rr = 4'b0010;
        @(negedge clk);
        chk("carry_grant", 32'(g_rr), 32'h2);
        @(negedge clk);
        chk("carry_result", 32'(res_rr), 32'h1FFFE);
        chk("carry_id", 32'(id_rr), 32'h1);

        // drain, then backpressure
        @(posedge clk); #1;
        req_rr = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        a_bus[0 +: W] = 16'h0005;
        b_bus[0 +: W] = 16'h0007;
        req_rr = 4'b0001;
        @(negedge clk);
        chk("bp_first_grant", 32'(g_rr), 32'h1);
        @(posedge clk); #1;
        rdy_rr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", 32'(v_rr), 32'h1);
            chk("bp_result", 32'(res_rr), 32'h0000C);
            chk("bp_busy", 32'(busy_rr), 32'h1);
            chk("bp_grant", 32'(g_rr), 32'h0);
        end
        @(posedge clk); #1;
        rdy_rr = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 32'(g_rr), 32'h1);
        chk("bp_release_busy", 32'(busy_rr), 32'h0);
        @(negedge clk);
        chk("bp_release_valid", 32'(v_rr), 32'h1);

        // reset while stalled
        @(posedge clk); #1;
        rdy_rr = 1'b0;
        @(posedge clk); #1;
        chk("stall_before_rst", 32'(v_rr), 32'h1);
        rst = 1'b1;
        req_rr = 4'b1111;
        #1;
        chk("midrst_valid", 32'(v_rr), 32'h0);
        chk("midrst_count", 32'(cnt_rr), 32'h0);
        chk("midrst_grant", 32'(g_rr), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_rr = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'(g_rr), 32'h1);

        // counter wrap: 65537 accepts, first accept is on the second edge
        repeat (65538) @(posedge clk);
        @(negedge clk);
        chk("count_wrap", 32'(cnt_rr), 32'h1);

        // fixed priority instance
        @(posedge clk); #1;
        req_rr = 4'b0000;
        req_fp = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fp_grant_hi", 32'(g_fp), 32'h4);
            if (k > 0) chk("fp_id_hi", 32'(id_fp), 32'h2);
        end
        @(posedge clk); #1;
        req_fp = 4'b0010;
        @(negedge clk);
        chk("fp_grant_lo", 32'(g_fp), 32'h2);
        @(posedge clk); #1;
        req_fp = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
